// File: rtl/morse_pkg.sv
// Shared definitions for the Morse front-end controller and the letter decoder.
package morse_pkg;

    localparam logic [6:0] ST_UNCAL     = 7'b000_0001;
    localparam logic [6:0] ST_CAL_ARM   = 7'b000_0010;
    localparam logic [6:0] ST_CAL_PRESS = 7'b000_0100;
    localparam logic [6:0] ST_CAL_GAP   = 7'b000_1000;
    localparam logic [6:0] ST_READY     = 7'b001_0000;
    localparam logic [6:0] ST_PRESS     = 7'b010_0000;
    localparam logic [6:0] ST_GAP       = 7'b100_0000;

    typedef enum logic [6:0] {
        UNCAL     = ST_UNCAL,
        CAL_ARM   = ST_CAL_ARM,
        CAL_PRESS = ST_CAL_PRESS,
        CAL_GAP   = ST_CAL_GAP,
        READY     = ST_READY,
        PRESS     = ST_PRESS,
        GAP       = ST_GAP
    } state_e;

    // Dash and letter-gap thresholds, in units of the learned dot length.
    localparam int DASH_MULT = 2;
    localparam int GAP_MULT  = 2;

endpackage

// File: rtl/morse_sat_counter.sv
// Tick-enabled duration counter that sticks at its maximum instead of wrapping.
module morse_sat_counter #(
    parameter int CNT_W = 12
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o,
    output logic [CNT_W-1:0] inc_o,
    output logic             sat_o
);

    localparam logic [CNT_W-1:0] MAX_CNT = '1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign sat_o   = (count_q == MAX_CNT);
    // Value the counter takes on the next enabled tick; lets the owner see thresholds early.
    assign inc_o   = sat_o ? count_q : count_q + CNT_W'(1);
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = inc_o;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/morse_key_ctrl.sv
// Morse key front end: learns the dot length, then emits L/S/LetterEnd/Timeout pulses.
module morse_key_ctrl
    import morse_pkg::*;
#(
    parameter int CNT_W         = 12,
    parameter int CAL_PRESSES   = 4,
    parameter int TIMEOUT_TICKS = 3000
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Tick,
    input  logic             Btn,
    input  logic             CalReq,
    output logic             L,
    output logic             S,
    output logic             LetterEnd,
    output logic             Timeout,
    output logic             Calibrated,
    output logic [CNT_W-1:0] DotLen,
    output logic             Busy,
    output logic [6:0]       State
);

    localparam int LOG2_CAL = $clog2(CAL_PRESSES);
    localparam int SUM_W    = CNT_W + LOG2_CAL;
    localparam int PCNT_W   = LOG2_CAL + 1;
    localparam logic [CNT_W:0]  TIMEOUT_THR = (CNT_W+1)'(TIMEOUT_TICKS);
    localparam logic [PCNT_W-1:0] LAST_PRESS = PCNT_W'(CAL_PRESSES - 1);

    state_e            state_q;
    logic [SUM_W-1:0]  sum_q;
    logic [PCNT_W-1:0] pcnt_q;
    logic              from_gap_q;
    logic              le_sent_q;
    logic              l_q, s_q, letter_end_q, timeout_q;
    logic              calibrated_q, busy_q;
    logic [CNT_W-1:0]  dot_len_q;

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic              cnt_sat;
    logic              cnt_clr;
    logic              cnt_en;
    logic [SUM_W-1:0]  sum_add;
    logic [CNT_W:0]    dash_thr;
    logic [CNT_W:0]    gap_thr;
    logic [CNT_W:0]    dur;
    logic [CNT_W:0]    gap_next;

    // Counter restarts on every press start and on every accepted release.
    assign cnt_clr = (Btn && (state_q == CAL_GAP || state_q == READY || state_q == GAP))
                   || (!Btn && state_q == PRESS);
    assign cnt_en  = Tick && (state_q == CAL_PRESS || state_q == PRESS || state_q == GAP);

    morse_sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .Clk     (Clk),
        .Reset   (Reset),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .count_o (cnt),
        .inc_o   (cnt_inc),
        .sat_o   (cnt_sat)
    );

    assign sum_add  = sum_q + SUM_W'(cnt);
    assign dash_thr = {1'b0, dot_len_q} * (CNT_W+1)'(DASH_MULT);
    assign gap_thr  = {1'b0, dot_len_q} * (CNT_W+1)'(GAP_MULT);
    assign dur      = {1'b0, cnt};
    assign gap_next = {1'b0, cnt_inc};

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= UNCAL;
            sum_q        <= '0;
            pcnt_q       <= '0;
            from_gap_q   <= 1'b0;
            le_sent_q    <= 1'b0;
            l_q          <= 1'b0;
            s_q          <= 1'b0;
            letter_end_q <= 1'b0;
            timeout_q    <= 1'b0;
            calibrated_q <= 1'b0;
            busy_q       <= 1'b0;
            dot_len_q    <= '0;
        end else begin
            l_q          <= 1'b0;
            s_q          <= 1'b0;
            letter_end_q <= 1'b0;
            timeout_q    <= 1'b0;
            if (CalReq) begin
                state_q      <= CAL_ARM;
                calibrated_q <= 1'b0;
                dot_len_q    <= '0;
                busy_q       <= 1'b1;
            end else begin
                case (state_q)
                    UNCAL: ;
                    CAL_ARM: begin
                        if (!Btn) begin
                            sum_q   <= '0;
                            pcnt_q  <= '0;
                            state_q <= CAL_GAP;
                        end
                    end
                    CAL_GAP: begin
                        if (Btn) state_q <= CAL_PRESS;
                    end
                    CAL_PRESS: begin
                        if (!Btn) begin
                            if (cnt == '0) begin
                                state_q <= CAL_GAP;
                            end else begin
                                sum_q  <= sum_add;
                                pcnt_q <= pcnt_q + PCNT_W'(1);
                                if (pcnt_q == LAST_PRESS) begin
                                    dot_len_q    <= sum_add[SUM_W-1:LOG2_CAL];
                                    calibrated_q <= 1'b1;
                                    busy_q       <= 1'b0;
                                    state_q      <= READY;
                                end else begin
                                    state_q <= CAL_GAP;
                                end
                            end
                        end
                    end
                    READY: begin
                        if (Btn) begin
                            from_gap_q <= 1'b0;
                            state_q    <= PRESS;
                        end
                    end
                    PRESS: begin
                        if (!Btn) begin
                            if (cnt == '0) begin
                                state_q <= from_gap_q ? GAP : READY;
                            end else begin
                                if (cnt_sat || dur >= dash_thr) begin
                                    l_q <= 1'b1;
                                end else begin
                                    s_q <= 1'b1;
                                end
                                le_sent_q <= 1'b0;
                                state_q   <= GAP;
                            end
                        end
                    end
                    GAP: begin
                        if (Btn) begin
                            from_gap_q <= 1'b1;
                            state_q    <= PRESS;
                        end else if (Tick) begin
                            // Both thresholds are checked independently so a short timeout
                            // still closes the letter in the same cycle.
                            if (!le_sent_q && gap_next >= gap_thr) begin
                                letter_end_q <= 1'b1;
                                le_sent_q    <= 1'b1;
                            end
                            if (gap_next >= TIMEOUT_THR) begin
                                timeout_q <= 1'b1;
                                state_q   <= READY;
                            end
                        end
                    end
                    default: state_q <= UNCAL;
                endcase
            end
        end
    end

    assign L          = l_q;
    assign S          = s_q;
    assign LetterEnd  = letter_end_q;
    assign Timeout    = timeout_q;
    assign Calibrated = calibrated_q;
    assign DotLen     = dot_len_q;
    assign Busy       = busy_q;
    assign State      = state_q;

endmodule

// File: tb/tb_morse_key_ctrl.sv
// Directed bench for morse_key_ctrl: calibration, classification, gaps, aborts and reset.
module tb_morse_key_ctrl;
    import morse_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Tick = 1'b0;
    logic        Btn = 1'b0;
    logic        CalReq = 1'b0;
    logic        L, S, LetterEnd, Timeout, Calibrated, Busy;
    logic [11:0] DotLen;
    logic [6:0]  State;

    int n_cmp = 0;
    int n_err = 0;
    int n_l = 0, n_s = 0, n_le = 0, n_to = 0, n_both = 0;

    typedef struct {
        int press;
        int gap;
        int exp_l;
        int exp_s;
        int exp_le;
    } vec_t;

    vec_t vecs[5];

    morse_key_ctrl #(
        .CNT_W         (12),
        .CAL_PRESSES   (4),
        .TIMEOUT_TICKS (3000)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Tick       (Tick),
        .Btn        (Btn),
        .CalReq     (CalReq),
        .L          (L),
        .S          (S),
        .LetterEnd  (LetterEnd),
        .Timeout    (Timeout),
        .Calibrated (Calibrated),
        .DotLen     (DotLen),
        .Busy       (Busy),
        .State      (State)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock; outputs are sampled on the falling edge and pulses tallied.
    task automatic cyc();
        @(negedge Clk);
        if (L)         n_l++;
        if (S)         n_s++;
        if (LetterEnd) n_le++;
        if (Timeout)   n_to++;
        if (L && S)    n_both++;
    endtask

    task automatic clr_counts();
        n_l = 0; n_s = 0; n_le = 0; n_to = 0;
    endtask

    task automatic do_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            Tick = 1'b1; cyc();
            Tick = 1'b0; cyc();
        end
    endtask

    // Press lasting exactly n ticks; returns on the falling edge after the release is seen.
    task automatic press(input int n);
        Btn = 1'b1; cyc();
        do_ticks(n);
        Btn = 1'b0; cyc();
    endtask

    task automatic calibrate(input int a, input int b, input int c, input int d);
        Btn = 1'b0; cyc(); cyc();
        press(a); press(b); press(c); press(d);
    endtask

    initial begin
        vecs[0] = '{press: 21,   gap: 0,  exp_l: 0, exp_s: 1, exp_le: 0};
        vecs[1] = '{press: 22,   gap: 21, exp_l: 1, exp_s: 0, exp_le: 0};
        vecs[2] = '{press: 10,   gap: 22, exp_l: 0, exp_s: 1, exp_le: 1};
        vecs[3] = '{press: 1,    gap: 50, exp_l: 0, exp_s: 1, exp_le: 1};
        vecs[4] = '{press: 5000, gap: 3,  exp_l: 1, exp_s: 0, exp_le: 0};

        // Reset values
        repeat (3) cyc();
        Reset = 1'b0;
        cyc();
        check("rst State", State, ST_UNCAL);
        check("rst Calibrated", Calibrated, 0);
        check("rst DotLen", DotLen, 0);
        check("rst Busy", Busy, 0);
        check("rst pulses", {L, S, LetterEnd, Timeout}, 0);

        // UNCAL ignores the key
        clr_counts();
        press(5);
        do_ticks(3);
        check("uncal State", State, ST_UNCAL);
        check("uncal pulses", n_l + n_s + n_le + n_to, 0);

        // Calibration 10,12,10,12 with a glitch before the last press
        clr_counts();
        CalReq = 1'b1; cyc(); CalReq = 1'b0;
        check("cal arm State", State, ST_CAL_ARM);
        check("cal arm Busy", Busy, 1);
        cyc();
        check("cal gap State", State, ST_CAL_GAP);
        press(10); press(12); press(10);
        Btn = 1'b1; cyc(); Btn = 1'b0; cyc();
        check("cal glitch Calibrated", Calibrated, 0);
        check("cal glitch State", State, ST_CAL_GAP);
        check("cal glitch Busy", Busy, 1);
        press(12);
        check("cal DotLen", DotLen, 11);
        check("cal Calibrated", Calibrated, 1);
        check("cal Busy", Busy, 0);
        check("cal State", State, ST_READY);
        check("cal no L/S", n_l + n_s, 0);

        // Glitch in READY
        clr_counts();
        Btn = 1'b1; cyc(); Btn = 1'b0; cyc();
        check("ready glitch State", State, ST_READY);
        check("ready glitch pulses", n_l + n_s, 0);

        // Classification table with DotLen = 11
        for (int i = 0; i < 5; i++) begin
            clr_counts();
            press(vecs[i].press);
            check($sformatf("vec%0d L edge", i), L, vecs[i].exp_l);
            check($sformatf("vec%0d S edge", i), S, vecs[i].exp_s);
            do_ticks(vecs[i].gap);
            check($sformatf("vec%0d L count", i), n_l, vecs[i].exp_l);
            check($sformatf("vec%0d S count", i), n_s, vecs[i].exp_s);
            check($sformatf("vec%0d LetterEnd count", i), n_le, vecs[i].exp_le);
            check($sformatf("vec%0d State", i), State, ST_GAP);
        end

        // Gap to LetterEnd, then on to Timeout
        clr_counts();
        press(5);
        check("gap S", n_s, 1);
        do_ticks(21);
        check("gap LE before", n_le, 0);
        Tick = 1'b1; cyc();
        check("gap LE at 22", LetterEnd, 1);
        Tick = 1'b0; cyc();
        check("gap LE width", LetterEnd, 0);
        do_ticks(2977);
        check("gap LE once", n_le, 1);
        check("gap TO before", n_to, 0);
        Tick = 1'b1; cyc();
        check("gap Timeout", Timeout, 1);
        check("gap TO State", State, ST_READY);
        Tick = 1'b0; cyc();
        check("gap TO width", Timeout, 0);

        // No gap counting in READY; the next press is a plain S
        clr_counts();
        do_ticks(30);
        press(3);
        check("post TO S", n_s, 1);
        check("post TO LE", n_le, 0);
        check("post TO Timeout", n_to, 0);

        // CalReq on the same edge as a release
        clr_counts();
        Btn = 1'b1; cyc();
        do_ticks(15);
        Btn = 1'b0; CalReq = 1'b1; cyc(); CalReq = 1'b0;
        check("abort L/S", n_l + n_s, 0);
        check("abort Calibrated", Calibrated, 0);
        check("abort DotLen", DotLen, 0);
        check("abort Busy", Busy, 1);
        check("abort State", State, ST_CAL_ARM);

        // Recalibration with truncating average (34/4)
        calibrate(8, 8, 9, 9);
        check("recal DotLen", DotLen, 8);
        check("recal Calibrated", Calibrated, 1);

        // CalReq while the key is held stays in CAL_ARM until release
        clr_counts();
        Btn = 1'b1; cyc();
        do_ticks(3);
        CalReq = 1'b1; cyc(); CalReq = 1'b0;
        do_ticks(3);
        check("held State", State, ST_CAL_ARM);
        check("held Busy", Busy, 1);
        check("held Calibrated", Calibrated, 0);
        Btn = 1'b0; cyc();
        check("held release State", State, ST_CAL_GAP);
        check("held L/S", n_l + n_s, 0);

        // Asynchronous reset while LetterEnd is high
        calibrate(8, 8, 9, 9);
        check("recal2 DotLen", DotLen, 8);
        press(4);
        do_ticks(15);
        Tick = 1'b1; cyc();
        check("pre-reset LetterEnd", LetterEnd, 1);
        #2 Reset = 1'b1;
        #1;
        check("async State", State, ST_UNCAL);
        check("async LetterEnd", LetterEnd, 0);
        check("async Calibrated", Calibrated, 0);
        check("async DotLen", DotLen, 0);
        check("async Busy", Busy, 0);
        Tick = 1'b0;
        #1 Reset = 1'b0;
        cyc();
        clr_counts();
        press(10);
        do_ticks(30);
        check("post reset pulses", n_l + n_s + n_le + n_to, 0);
        check("post reset State", State, ST_UNCAL);

        check("L and S never together", n_both, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/morse_key_ctrl.md
# morse_key_ctrl

Front-end controller for the Morse decoder. It times the debounced key against a 1 ms tick and learns a user-specific dot length during a calibration phase. It then classifies each key press as short (S) or long (L), and detects letter gaps and idle timeouts. Its one-cycle L/S/LetterEnd/Timeout pulses sequence the downstream letter state machine.

## Interface
Parameters:
- CNT_W, 12: width of the duration counters and of DotLen, in ticks.
- CAL_PRESSES, 4: dot presses averaged during calibration. Must be a power of two.
- TIMEOUT_TICKS, 3000: gap length, in ticks, that aborts the current letter.

Ports:
- Clk, input, 1: clock.
- Reset, input, 1: asynchronous, active-high.
- Tick, input, 1: single-cycle timebase enable, 1 ms period.
- Btn, input, 1: debounced key, synchronous to Clk, 1 = pressed.
- CalReq, input, 1: single-cycle pulse that starts or restarts calibration.
- L, output, 1: single-cycle pulse for a long press (dash).
- S, output, 1: single-cycle pulse for a short press (dot).
- LetterEnd, output, 1: single-cycle pulse marking the end of a letter.
- Timeout, output, 1: single-cycle pulse for an idle abort.
- Calibrated, output, 1: level, high once DotLen is valid.
- DotLen, output, CNT_W: learned dot duration in ticks.
- Busy, output, 1: level, high while calibrating.

## Operation
- States: UNCAL, CAL_ARM, CAL_PRESS, CAL_GAP, READY, PRESS, GAP.
- Reset values:
  - State = UNCAL.
  - All pulse outputs = 0.
  - Calibrated = 0, DotLen = 0, Busy = 0.
- UNCAL: ignores Btn. CalReq moves to CAL_ARM.
- CAL_ARM: waits for Btn = 0, then clears the sum and press count and goes to CAL_GAP.
- CAL_GAP: Btn = 1 clears the duration counter and goes to CAL_PRESS.
- CAL_PRESS: counts Tick cycles. On Btn = 0:
  - a duration of 0 is ignored (glitch); go back to CAL_GAP;
  - otherwise add the duration to the sum (width CNT_W + log2(CAL_PRESSES)) and increment the press count;
  - after the last press, DotLen = sum >> log2(CAL_PRESSES) (truncating), Calibrated = 1, go to READY;
  - otherwise return to CAL_GAP.
- Busy = 1 in CAL_ARM, CAL_GAP and CAL_PRESS.
- READY: Btn = 1 clears the counter and goes to PRESS. No gap counting in READY.
- PRESS: counts ticks. On Btn = 0:
  - duration 0: no pulse, return to whichever of READY or GAP preceded the press;
  - duration ≥ 2·DotLen: pulse L;
  - otherwise: pulse S.
  - After a pulse, clear the counter, clear the LetterEnd-sent flag, and go to GAP.
- GAP:
  - counts ticks with Btn = 0;
  - when the count reaches 2·DotLen, pulse LetterEnd once per gap (flag-guarded);
  - when the count reaches TIMEOUT_TICKS, pulse Timeout and go to READY;
  - Btn = 1 goes to PRESS.
- Arithmetic:
  - 2·DotLen is computed in CNT_W+1 bits, with no overflow.
  - Duration counters saturate at 2^CNT_W − 1 and never wrap.
  - A saturated press is classified as L.
- CalReq has top priority in every state. It returns the block to CAL_ARM, clears Calibrated and DotLen, and suppresses any L/S/LetterEnd/Timeout pulse due in that cycle.
- If TIMEOUT_TICKS ≤ 2·DotLen, LetterEnd (if not already sent) and Timeout pulse in the same cycle.
- L and S are never high together.

## Timing
- Btn is sampled on every Clk edge. Counters advance only on cycles with Tick = 1.
- Pulse latency:
  - L/S are registered and go high in the cycle after the first edge that samples Btn = 0 in PRESS. Width is exactly one Clk.
  - LetterEnd/Timeout go high in the cycle after the Tick that reaches the threshold. Width is exactly one Clk.
- Calibrated and DotLen update in the same cycle as the last calibration release is processed.
- Reset mid-press or mid-calibration: everything returns to the reset values immediately, with no pulses.

## Structure
- Shared package morse_pkg holds:
  - state localparams, one-hot encoded, 7 bits;
  - DASH_MULT = 2 and GAP_MULT = 2, also used by the letter decoder.
- Sub-module morse_sat_counter: CNT_W-bit saturating counter with synchronous clear and Tick enable. The controller instantiates it once and shares it between press and gap timing.

## Test plan
- Calibration with Reset then CalReq, presses of 10, 12, 10, 12 ticks → DotLen = 11, Calibrated = 1, Busy falls; no L/S pulses during calibration.
- Classification with DotLen = 11:
  - press 21 ticks → one S pulse;
  - press 22 ticks → one L pulse;
  - press 5000 ticks (counter saturates) → L.
- Gap handling with DotLen = 11: S, then 22-tick gap → LetterEnd once; continuing to 3000 ticks → one Timeout, state READY; a subsequent press yields S with no extra LetterEnd.
- Glitch rejection: Btn high for 0 ticks (between Ticks) in READY, and also during calibration → no pulse, press count unchanged.
- Aborts:
  - CalReq in the same cycle as a release in PRESS → no L/S, Calibrated = 0, DotLen = 0, Busy = 1;
  - CalReq while Btn is held → waits in CAL_ARM until release.
- Asynchronous Reset asserted mid-GAP, between Clk edges → all outputs 0 immediately, state UNCAL; Btn activity afterwards produces no pulses.
